// File: rtl/fifo_rd_pkg.sv
// Shared encodings and defaults for the FIFO burst read path.
// No logic; constants and the controller state type only.
// Imported by the reader top and its buffer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } rd_state_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_CNT_W     = 5;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_TIMEOUT   = 8;
    localparam int FIFO_DEPTH    = 16;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry {last, data} fall-through buffer feeding the downstream valid/ready port.
// Latency: zero when empty (push bypasses straight to the output), else head of queue.
// Backpressure: holds head stable while out_rdy is low; caller must not push when full.
module rd_skid_buf #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              push_last,
    input  logic [DATA_W-1:0] push_dat,
    output logic [1:0]        occ,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              out_last,
    output logic [DATA_W-1:0] out_dat
);

    logic [DATA_W:0] mem [2];
    logic [DATA_W:0] head;
    logic            wr_ptr;
    logic            rd_ptr;
    logic            bypass;
    logic            do_pop;
    logic            do_write;
    logic            pop_mem;

    assign bypass   = (occ == 2'd0);
    assign out_vld  = !bypass || push;
    assign do_pop   = out_vld && out_rdy;
    // A word consumed in the same cycle it arrives never occupies a slot.
    assign do_write = push && !(bypass && do_pop);
    assign pop_mem  = do_pop && !bypass;

    always_comb begin
        head = '0;
        if (!bypass)   head = mem[rd_ptr];
        else if (push) head = {push_last, push_dat};
    end

    assign out_last = head[DATA_W];
    assign out_dat  = head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= {push_last, push_dat};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_write) wr_ptr <= !wr_ptr;
            if (pop_mem)  rd_ptr <= !rd_ptr;
            occ <= occ + {1'b0, do_write} - {1'b0, pop_mem};
        end
    end

endmodule

// File: rtl/synchronous_fifo.sv
// Generic 16-deep FIFO with registered read data and occupancy count.
// Latency: read data valid the cycle after pop; num/empty/full update every edge.
// Backpressure: push ignored when full, pop ignored when empty.
module synchronous_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_dat,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  num
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (num == '0);
    assign full    = (num == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            num    <= '0;
            rd_dat <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_dat <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   num <= num + CNT_W'(1);
                2'b01:   num <= num - CNT_W'(1);
                default: num <= num;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops the FIFO in bursts and streams words out with a last marker.
// Latency: first pop one cycle after the start condition, first m_valid the cycle after that.
// Backpressure: at most two words outstanding (buffered + in flight); pops stall otherwise.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              fifo_pop,
    input  logic [DATA_W-1:0] fifo_out,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_num,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
);

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    rd_state_t        state_q, state_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] pops_q;
    logic [WC_W-1:0]  wcnt_q;
    logic             inflight_q;
    logic             inflight_last_q;
    logic [1:0]       buf_occ;
    logic [1:0]       slots_used;
    logic             partial;
    logic             full_go;
    logic             tmo_go;
    logic             last_acc;

    assign partial    = (fifo_num != '0) && (fifo_num < CNT_W'(BURST_LEN));
    assign full_go    = (fifo_num >= CNT_W'(BURST_LEN));
    assign tmo_go     = (wcnt_q == WC_W'(TIMEOUT - 1)) && (fifo_num != '0);
    assign slots_used = buf_occ + {1'b0, inflight_q};
    assign last_acc   = m_valid && m_ready && m_last;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_go || tmo_go) state_d = BURST;
            end
            BURST: begin
                fifo_pop = (pops_q != len_q) && !fifo_empty && (slots_used < 2'd2);
                // With m_ready high the last word can leave before FLUSH is reached.
                if (pops_q == len_q) state_d = last_acc ? IDLE : FLUSH;
            end
            FLUSH: begin
                if (last_acc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            len_q           <= '0;
            pops_q          <= '0;
            wcnt_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= fifo_pop;
            inflight_last_q <= fifo_pop && (pops_q == len_q - CNT_W'(1));
            if (fifo_pop) pops_q <= pops_q + CNT_W'(1);
            if (state_q == IDLE) begin
                if (full_go) begin
                    len_q  <= CNT_W'(BURST_LEN);
                    pops_q <= '0;
                    wcnt_q <= '0;
                end else if (tmo_go) begin
                    len_q  <= fifo_num;
                    pops_q <= '0;
                    wcnt_q <= '0;
                end else if (partial) begin
                    wcnt_q <= wcnt_q + WC_W'(1);
                end else begin
                    wcnt_q <= '0;
                end
            end else begin
                wcnt_q <= '0;
            end
        end
    end

    rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_last (inflight_last_q),
        .push_dat  (fifo_out),
        .occ       (buf_occ),
        .out_vld   (m_valid),
        .out_rdy   (m_ready),
        .out_last  (m_last),
        .out_dat   (m_data)
    );

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the 16-deep `synchronous_fifo`. It watches the FIFO fill level and issues `pop` pulses in bursts. It converts the FIFO's registered read data into a valid/ready stream with a `last` marker. It sits between the FIFO output port and any downstream consumer, and is the only agent allowed to pop the FIFO.

## Interface
Parameters:
- `DATA_W`, 16, data width; must equal the FIFO width.
- `CNT_W`, 5, width of the FIFO `num` occupancy count.
- `BURST_LEN`, 4, words per full burst; legal range 1..16.
- `TIMEOUT`, 8, consecutive cycles with a partial fill before a short burst is forced; must be ≥1.

Ports:
- `clk`, in, 1, single clock; everything is rising-edge.
- `reset`, in, 1, synchronous, active-low: `reset==0` at a clock edge resets the block.
- `fifo_pop`, out, 1, pop strobe to the FIFO.
- `fifo_out`, in, DATA_W, FIFO read data; valid in the cycle after a pop.
- `fifo_empty`, in, 1, FIFO empty flag.
- `fifo_num`, in, CNT_W, FIFO occupancy.
- `m_valid`, out, 1, downstream word valid.
- `m_ready`, in, 1, downstream accept.
- `m_data`, out, DATA_W, downstream word.
- `m_last`, out, 1, marks the final word of a burst.
- `busy`, out, 1, high while not in IDLE.

## Operation
- **FSM states:** IDLE, BURST, FLUSH.
- **IDLE:**
  - A wait counter `wcnt` counts cycles with `0 < fifo_num < BURST_LEN`. It clears when `fifo_empty==1`.
  - If `fifo_num ≥ BURST_LEN`: latch `len = BURST_LEN` and go to BURST.
  - Else if `wcnt == TIMEOUT-1` and `fifo_num > 0`: latch `len = fifo_num` and go to BURST.
  - The full-burst condition has priority over timeout.
- **BURST:**
  - A pop counter counts up to `len`.
  - `fifo_pop = (pops_issued < len) && !fifo_empty && (buf_occ + inflight < 2)`.
  - Popped data is written into the skid buffer one cycle later.
  - When `pops_issued == len`, go to FLUSH.
- **FLUSH:** wait until the word tagged last is accepted (`m_valid && m_ready && m_last`), then go to IDLE and clear `wcnt`.
- **Skid buffer:**
  - 2-entry FIFO; each entry holds `{last, data}`.
  - `last` is set on the word whose pop index equals `len-1`.
  - `m_valid` = buffer non-empty; `m_data`/`m_last` = head entry.
- **Handshake:**
  - A word transfers when `m_valid && m_ready`.
  - While `m_valid==1` and `m_ready==0`, `m_data`/`m_last` hold stable.
  - `m_valid` never drops without a transfer.
- **Empty guard:** `fifo_pop` is never asserted while `fifo_empty==1`. If the FIFO goes empty mid-burst (illegal external pop), popping stalls and the burst resumes when data appears.
- **Widths:**
  - `len` is CNT_W bits.
  - Pop and accept counters are CNT_W bits, compared for equality only.
  - `len` is never 0.
- **Reset (reset==0):**
  - FSM → IDLE, counters = 0, buffer emptied, in-flight capture discarded.
  - `fifo_pop=0`, `m_valid=0`, `m_data=0`, `m_last=0`, `busy=0`.

## Timing
- **Full-burst start:** the condition is seen in IDLE at edge N; state = BURST and `fifo_pop=1` in cycle N+1; first `m_valid` in cycle N+2.
- **Throughput:** with `m_ready` held high, 1 word/cycle; a 4-word burst gives `m_valid` high for 4 consecutive cycles and `m_last` on the 4th.
- **Backpressure:** with `m_ready` low, at most 2 words are popped ahead (buffer + in-flight); popping resumes the cycle after the first accept frees a slot.
- **Timeout:** the short burst starts `TIMEOUT` cycles after the first cycle of a stable partial fill.
- **Turnaround:** IDLE is re-entered the cycle after the last accept; `busy` falls in that same cycle. A new burst can begin from the following edge.
- **Reset timing:** reset is sampled only at the clock edge. Asserting it mid-burst takes effect at the next edge regardless of `m_ready`.

## Structure
- **Package `fifo_rd_pkg`:**
  - FSM state encodings (IDLE=2'd0, BURST=2'd1, FLUSH=2'd2).
  - Default DATA_W/CNT_W/BURST_LEN/TIMEOUT constants.
- **Sub-module `rd_skid_buf`:** 2-entry `{last, data}` buffer with push/pop, occupancy, valid/ready output. The top-level holds the FSM, counters and pop gating.
- **Test wrapper:** the test wrapper instantiates `synchronous_fifo` plus `fifo_burst_reader`, joined on `fifo_pop/fifo_out/fifo_empty/fifo_num`.

## Test plan
- **Full burst:** reset, push 4 words 0x1111..0x4444, `m_ready=1` → 4 consecutive `m_valid` cycles starting 2 cycles after `num` reaches 4; data in order; `m_last` only on 0x4444; `busy` then drops.
- **Timeout:** push 2 words (0xA0A0, 0xB0B0) and wait → short burst of 2 starts 8 cycles later; `m_last` on 0xB0B0; no further pops.
- **Backpressure:** push 8 words, `m_ready=0` for 10 cycles → exactly 2 pops; `m_data=first word` stable throughout. Release → remaining words in order; 2 bursts, `m_last` on words 4 and 8.
- **Burst length cap:** fill to 16 (full) → 4 bursts of 4; never `fifo_pop` with `fifo_empty=1`; FIFO ends empty.
- **Reset mid-burst:** pull `reset=0` for 1 cycle during burst word 2 → next cycle all outputs 0 and FSM in IDLE; remaining FIFO data is treated per FIFO reset, no spurious `m_valid`.
- **Random m_ready:** 100 random words with random `m_ready` → output sequence equals input sequence; `m_last` count = number of bursts started.
